// File: rtl/debug_hexcmd_rx_if.sv
// Host-to-core hex debug channel: UART line in, committed debug registers out.
// The master modport is the host/stimulus side, the slave modport is the receiver.
interface debug_hexcmd_rx_if;
   logic         rxd_i;
   logic [127:0] vout_o;
   logic [4:0]   nbytes_o;
   logic         frame_ok_o;
   logic         frame_err_o;

   modport master (output rxd_i, input vout_o, nbytes_o, frame_ok_o, frame_err_o);
   modport slave  (input rxd_i, output vout_o, nbytes_o, frame_ok_o, frame_err_o);
endinterface

// File: rtl/debug_hexcmd_rx.sv
// UART 8N1 receiver plus ASCII-hex line parser that atomically loads up to 16 debug bytes.
// Optional feature: define DEBUG_HEXCMD_ADDR_EN to allow an "@h" start-register prefix.
module debug_hexcmd_rx #(
   parameter int CLKS_PER_BIT = 243
) (
   input  logic              clk,
   input  logic              rst,
   debug_hexcmd_rx_if.slave  bus
);
`ifdef DEBUG_HEXCMD_ADDR_EN
   localparam bit ADDR_EN = 1'b1;
`else
   localparam bit ADDR_EN = 1'b0;
`endif
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   uart_state_t   state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   logic          byte_valid_q, stop_err_q;

   logic [7:0]    shadow_q [16];
   logic [5:0]    dcnt_q;
   logic [4:0]    idx_q, base_q, nbytes_q;
   logic          err_q, started_q, addr_pend_q;
   logic          ok_q, ferr_q;

   logic          is_hex, is_term, commit_now;
   logic [3:0]    nib;

   // Sync registers reset to idle-high so reset release never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= bus.rxd_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (rx_prev_q && !rx_sync_q) state_q <= START;
            end
            START: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= rx_sync_q ? IDLE : DATA;
               end
            end
            DATA: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_sync_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= STOP;
               end
            end
            STOP: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                  cnt_q        <= '0;
                  byte_valid_q <= rx_sync_q;
                  stop_err_q   <= !rx_sync_q;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      is_hex = 1'b1;
      nib    = 4'h0;
      if (shift_q >= 8'h30 && shift_q <= 8'h39)
         nib = shift_q[3:0];
      else if ((shift_q >= 8'h41 && shift_q <= 8'h46) || (shift_q >= 8'h61 && shift_q <= 8'h66))
         nib = shift_q[3:0] + 4'd9;
      else
         is_hex = 1'b0;
      is_term    = (shift_q == 8'h0D) || (shift_q == 8'h0A);
      commit_now = byte_valid_q && is_term && (dcnt_q != 6'd0) && !dcnt_q[0]
                   && !err_q && !addr_pend_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
         dcnt_q      <= '0;
         idx_q       <= '0;
         base_q      <= '0;
         nbytes_q    <= '0;
         err_q       <= 1'b0;
         started_q   <= 1'b0;
         addr_pend_q <= 1'b0;
         ok_q        <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         ok_q   <= 1'b0;
         ferr_q <= 1'b0;
         if (stop_err_q) err_q <= 1'b1;
         if (byte_valid_q) begin
            if (is_term) begin
               // A bare terminator (e.g. the LF of CRLF) is silently swallowed.
               if (commit_now) begin
                  ok_q     <= 1'b1;
                  nbytes_q <= idx_q - base_q;
               end else if (dcnt_q != 6'd0 || err_q || addr_pend_q) begin
                  ferr_q <= 1'b1;
               end
               dcnt_q      <= '0;
               idx_q       <= '0;
               base_q      <= '0;
               err_q       <= 1'b0;
               started_q   <= 1'b0;
               addr_pend_q <= 1'b0;
            end else begin
               started_q <= 1'b1;
               if (addr_pend_q) begin
                  addr_pend_q <= 1'b0;
                  if (is_hex) begin
                     base_q <= {1'b0, nib};
                     idx_q  <= {1'b0, nib};
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (is_hex) begin
                  if (idx_q[4]) begin
                     err_q <= 1'b1;
                  end else begin
                     shadow_q[idx_q[3:0]] <= {shadow_q[idx_q[3:0]][3:0], nib};
                     dcnt_q <= dcnt_q + 1'b1;
                     if (dcnt_q[0]) idx_q <= idx_q + 1'b1;
                  end
               end else if (shift_q == 8'h20) begin
                  if (dcnt_q[0]) err_q <= 1'b1;
               end else if (ADDR_EN && shift_q == 8'h40 && !started_q) begin
                  addr_pend_q <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
            end
         end
      end
   end

   // Each register byte loads only inside the committed window [base, idx).
   for (genvar gi = 0; gi < 16; gi++) begin : g_vout
      logic [7:0] byte_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            byte_q <= '0;
         else if (commit_now && (5'(gi) >= base_q) && (5'(gi) < idx_q))
            byte_q <= shadow_q[gi];
      end
      assign bus.vout_o[8*gi +: 8] = byte_q;
   end

   assign bus.nbytes_o    = nbytes_q;
   assign bus.frame_ok_o  = ok_q;
   assign bus.frame_err_o = ferr_q;
endmodule
